// File: rtl/register_set_master.sv
// Single-outstanding req/ack initiator for the byte-addressed register set.
// Optional WAIT timeout is enabled by defining REG_MASTER_TIMEOUT_EN.
module register_set_master #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_wnr,
  input  logic [1:0]              cmd_size,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [4*DATA_WIDTH-1:0] cmd_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [4*DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]              rsp_status,
  output logic                    rs_wnr,
  output logic [1:0]              rs_req,
  output logic [ADDR_WIDTH-1:0]   rs_address,
  output logic [4*DATA_WIDTH-1:0] rs_data_in,
  input  logic                    rs_ack,
  input  logic [4*DATA_WIDTH-1:0] rs_data_out
);

  localparam int unsigned BUS_W = 4 * DATA_WIDTH;
  localparam logic [ADDR_WIDTH:0] ADDR_SPACE = {1'b1, {ADDR_WIDTH{1'b0}}};

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_TIMEOUT = 2'd1;
  localparam logic [1:0] ST_ILLEGAL = 2'd2;
  localparam logic [1:0] ST_RANGE   = 2'd3;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeout_range_check
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  function automatic int unsigned nbytes(input logic [1:0] size);
    case (size)
      2'd1:    return 1;
      2'd2:    return 2;
      2'd3:    return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic [BUS_W-1:0] lane_mask(input logic [1:0] size);
    logic [BUS_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (i < nbytes(size)) m[i*DATA_WIDTH +: DATA_WIDTH] = '1;
    end
    return m;
  endfunction

  state_t                 state_q, state_d;
  logic                   cmd_ready_q, cmd_ready_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [BUS_W-1:0]       rsp_rdata_q, rsp_rdata_d;
  logic [1:0]             rsp_status_q, rsp_status_d;
  logic                   rs_wnr_q, rs_wnr_d;
  logic [1:0]             rs_req_q, rs_req_d;
  logic [ADDR_WIDTH-1:0]  rs_address_q, rs_address_d;
  logic [BUS_W-1:0]       rs_data_in_q, rs_data_in_d;
  logic [1:0]             size_q, size_d;
  logic [ADDR_WIDTH:0]    end_addr;
`ifdef REG_MASTER_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0]             wcnt_q, wcnt_d;
`endif

  assign end_addr = {1'b0, cmd_addr} + (ADDR_WIDTH+1)'(nbytes(cmd_size));

  always_comb begin
    state_d      = state_q;
    cmd_ready_d  = cmd_ready_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_status_d = rsp_status_q;
    rs_wnr_d     = rs_wnr_q;
    rs_req_d     = rs_req_q;
    rs_address_d = rs_address_q;
    rs_data_in_d = rs_data_in_q;
    size_d       = size_q;
`ifdef REG_MASTER_TIMEOUT_EN
    wcnt_d       = wcnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid) begin
          cmd_ready_d = 1'b0;
          size_d      = cmd_size;
          rsp_rdata_d = '0;
          if (cmd_size == 2'd0) begin
            state_d      = S_RESP;
            rsp_status_d = ST_ILLEGAL;
          end else if (end_addr > ADDR_SPACE) begin
            state_d      = S_RESP;
            rsp_status_d = ST_RANGE;
          end else begin
            state_d      = S_ISSUE;
            rs_req_d     = cmd_size;
            rs_wnr_d     = cmd_wnr;
            rs_address_d = cmd_addr;
            rs_data_in_d = cmd_wdata & lane_mask(cmd_size);
          end
        end
      end
      S_ISSUE: begin
        rs_req_d = '0;
        state_d  = S_WAIT;
`ifdef REG_MASTER_TIMEOUT_EN
        wcnt_d   = '0;
`endif
      end
      S_WAIT: begin
        if (rs_ack) begin
          state_d      = S_RESP;
          rsp_valid_d  = 1'b1;
          rsp_status_d = ST_OK;
          rsp_rdata_d  = rs_wnr_q ? '0 : (rs_data_out & lane_mask(size_q));
        end
`ifdef REG_MASTER_TIMEOUT_EN
        else if (wcnt_q == WAIT_LAST) begin
          state_d      = S_RESP;
          rsp_valid_d  = 1'b1;
          rsp_status_d = ST_TIMEOUT;
          rsp_rdata_d  = '0;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
`endif
      end
      S_RESP: begin
        // Rejected commands enter RESP with valid still low; it rises one edge later.
        if (!rsp_valid_q) begin
          rsp_valid_d = 1'b1;
        end else if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cmd_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_status_q <= '0;
      rs_wnr_q     <= 1'b0;
      rs_req_q     <= '0;
      rs_address_q <= '0;
      rs_data_in_q <= '0;
      size_q       <= '0;
`ifdef REG_MASTER_TIMEOUT_EN
      wcnt_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cmd_ready_q  <= cmd_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_status_q <= rsp_status_d;
      rs_wnr_q     <= rs_wnr_d;
      rs_req_q     <= rs_req_d;
      rs_address_q <= rs_address_d;
      rs_data_in_q <= rs_data_in_d;
      size_q       <= size_d;
`ifdef REG_MASTER_TIMEOUT_EN
      wcnt_q       <= wcnt_d;
`endif
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_status = rsp_status_q;
  assign rs_wnr     = rs_wnr_q;
  assign rs_req     = rs_req_q;
  assign rs_address = rs_address_q;
  assign rs_data_in = rs_data_in_q;

endmodule

// File: tb/tb_register_set_master.sv
// Directed bench for register_set_master with a byte-array register set responder.
module tb_register_set_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_wnr;
  logic [1:0]  cmd_size;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_status;
  logic        rs_wnr;
  logic [1:0]  rs_req;
  logic [7:0]  rs_address;
  logic [31:0] rs_data_in;
  logic        rs_ack;
  logic [31:0] rs_data_out;

  logic ack_q = 1'b0;
  logic man_ack;
  logic auto_ack;
  assign rs_ack = ack_q | man_ack;

  int checks = 0;
  int errors = 0;

  register_set_master #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(8),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wnr(cmd_wnr),
    .cmd_size(cmd_size), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_status(rsp_status),
    .rs_wnr(rs_wnr), .rs_req(rs_req), .rs_address(rs_address),
    .rs_data_in(rs_data_in), .rs_ack(rs_ack), .rs_data_out(rs_data_out)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // Register set: zero-wait ack; reads return 4 raw bytes so master masking is visible.
  logic [7:0] mem [256];
  always @(posedge clk) begin
    ack_q <= 1'b0;
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      rs_data_out <= 32'h0;
    end else if (rs_req != 2'd0 && auto_ack) begin
      if (rs_wnr) begin
        for (int k = 0; k < 4; k++)
          if (k < ((rs_req == 2'd3) ? 4 : int'(rs_req)))
            mem[rs_address + 8'(k)] <= rs_data_in[k*8 +: 8];
        rs_data_out <= 32'hDEADBEEF;
      end else begin
        rs_data_out <= {mem[rs_address + 8'd3], mem[rs_address + 8'd2],
                        mem[rs_address + 8'd1], mem[rs_address]};
      end
      ack_q <= 1'b1;
    end
  end

  int          req_cycles = 0;
  int          consec = 0;
  logic        prev_nz = 1'b0;
  logic [1:0]  last_req = 2'd0;
  logic [31:0] last_din = 32'h0;
  always @(posedge clk) begin
    if (rs_req != 2'd0) begin
      req_cycles++;
      last_req = rs_req;
      last_din = rs_data_in;
      if (prev_nz) consec++;
    end
    prev_nz = (rs_req != 2'd0);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic send(input logic wnr, input logic [1:0] size, input logic [7:0] addr,
                      input logic [31:0] wdata);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wnr = wnr; cmd_size = size; cmd_addr = addr; cmd_wdata = wdata;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int budget, output int lat);
    lat = -1;
    for (int n = 1; n <= budget; n++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic handshake();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic run(input logic wnr, input logic [1:0] size, input logic [7:0] addr,
                     input logic [31:0] wdata, output int lat, output logic [1:0] st,
                     output logic [31:0] rd);
    send(wnr, size, addr, wdata);
    wait_rsp(40, lat);
    st = rsp_status;
    rd = rsp_rdata;
    handshake();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " cmd_ready"}, 32'(cmd_ready), 32'h1);
    chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'h0);
    chk({tag, " rsp_rdata"}, rsp_rdata, 32'h0);
    chk({tag, " rsp_status"}, 32'(rsp_status), 32'h0);
    chk({tag, " rs_req"}, 32'(rs_req), 32'h0);
    chk({tag, " rs_wnr"}, 32'(rs_wnr), 32'h0);
    chk({tag, " rs_address"}, 32'(rs_address), 32'h0);
    chk({tag, " rs_data_in"}, rs_data_in, 32'h0);
  endtask

  typedef struct {
    logic        wnr;
    logic [1:0]  size;
    logic [7:0]  addr;
    logic [31:0] wdata;
    int          lat;
    logic [1:0]  status;
    logic [31:0] rdata;
    int          nreq;
    logic [1:0]  req;
    logic [31:0] din;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int          lat;
    int          r0;
    logic [1:0]  st;
    logic [31:0] rd;
    logic        seen;

    vecs[0]  = '{1'b1, 2'd3, 8'h10, 32'hDDCCBBAA, 2, 2'd0, 32'h0,        1, 2'd3, 32'hDDCCBBAA};
    vecs[1]  = '{1'b0, 2'd3, 8'h10, 32'hCAFEF00D, 2, 2'd0, 32'hDDCCBBAA, 1, 2'd3, 32'hCAFEF00D};
    vecs[2]  = '{1'b0, 2'd1, 8'h11, 32'hCAFEF00D, 2, 2'd0, 32'h000000BB, 1, 2'd1, 32'h0000000D};
    vecs[3]  = '{1'b1, 2'd2, 8'h20, 32'hFFFF1234, 2, 2'd0, 32'h0,        1, 2'd2, 32'h00001234};
    vecs[4]  = '{1'b0, 2'd3, 8'h20, 32'h0,        2, 2'd0, 32'h00001234, 1, 2'd3, 32'h0};
    vecs[5]  = '{1'b0, 2'd2, 8'h10, 32'h0,        2, 2'd0, 32'h0000BBAA, 1, 2'd2, 32'h0};
    vecs[6]  = '{1'b1, 2'd3, 8'hFE, 32'h01020304, 1, 2'd3, 32'h0,        0, 2'd0, 32'h0};
    vecs[7]  = '{1'b1, 2'd3, 8'hFC, 32'h11223344, 2, 2'd0, 32'h0,        1, 2'd3, 32'h11223344};
    vecs[8]  = '{1'b0, 2'd3, 8'hFC, 32'h0,        2, 2'd0, 32'h11223344, 1, 2'd3, 32'h0};
    vecs[9]  = '{1'b1, 2'd0, 8'h40, 32'h12345678, 1, 2'd2, 32'h0,        0, 2'd0, 32'h0};
    vecs[10] = '{1'b1, 2'd1, 8'hFF, 32'hA5A5A55A, 2, 2'd0, 32'h0,        1, 2'd1, 32'h0000005A};
    vecs[11] = '{1'b0, 2'd2, 8'hFF, 32'h0,        1, 2'd3, 32'h0,        0, 2'd0, 32'h0};
    vecs[12] = '{1'b0, 2'd2, 8'hFE, 32'h0,        2, 2'd0, 32'h00005A22, 1, 2'd2, 32'h0};

    reset = 1'b1; cmd_valid = 1'b0; cmd_wnr = 1'b0; cmd_size = 2'd0; cmd_addr = 8'h0;
    cmd_wdata = 32'h0; rsp_ready = 1'b0; man_ack = 1'b0; auto_ack = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1 chk_reset_outputs("reset");

    for (int i = 0; i < 13; i++) begin
      chk($sformatf("v%0d cmd_ready before", i), 32'(cmd_ready), 32'h1);
      r0 = req_cycles;
      run(vecs[i].wnr, vecs[i].size, vecs[i].addr, vecs[i].wdata, lat, st, rd);
      chk($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d status", i), 32'(st), 32'(vecs[i].status));
      if (vecs[i].status == 2'd0) chk($sformatf("v%0d rdata", i), rd, vecs[i].rdata);
      chk($sformatf("v%0d req cycles", i), 32'(req_cycles - r0), 32'(vecs[i].nreq));
      if (vecs[i].nreq != 0) begin
        chk($sformatf("v%0d rs_req", i), 32'(last_req), 32'(vecs[i].req));
        chk($sformatf("v%0d rs_data_in", i), last_din, vecs[i].din);
      end
      chk($sformatf("v%0d rsp_valid after", i), 32'(rsp_valid), 32'h0);
    end

    // Backpressure: response held 5 cycles while a new command waits.
    send(1'b0, 2'd3, 8'h10, 32'h0);
    wait_rsp(40, lat);
    chk("bp latency", 32'(lat), 32'd2);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wnr = 1'b1; cmd_size = 2'd1; cmd_addr = 8'h10; cmd_wdata = 32'h77;
    r0 = req_cycles;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp%0d rsp_valid", c), 32'(rsp_valid), 32'h1);
      chk($sformatf("bp%0d rsp_rdata", c), rsp_rdata, 32'hDDCCBBAA);
      chk($sformatf("bp%0d rsp_status", c), 32'(rsp_status), 32'h0);
      chk($sformatf("bp%0d cmd_ready", c), 32'(cmd_ready), 32'h0);
    end
    cmd_valid = 1'b0;
    chk("bp no request", 32'(req_cycles - r0), 32'h0);
    handshake();
    chk("bp cmd_ready after", 32'(cmd_ready), 32'h1);
    chk("bp rsp_valid after", 32'(rsp_valid), 32'h0);
    run(1'b0, 2'd1, 8'h10, 32'h0, lat, st, rd);
    chk("bp readback", rd, 32'h000000AA);

    // No ack from the register set, then a late ack pulse.
    @(negedge clk) auto_ack = 1'b0;
    r0 = req_cycles;
    send(1'b1, 2'd1, 8'h30, 32'h99);
`ifdef REG_MASTER_TIMEOUT_EN
    wait_rsp(40, lat);
    chk("to latency", 32'(lat), 32'd5);
    chk("to status", 32'(rsp_status), 32'd1);
    chk("to rdata", rsp_rdata, 32'h0);
    handshake();
    @(negedge clk) man_ack = 1'b1;
    @(negedge clk) man_ack = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1 if (rsp_valid) seen = 1'b1;
    end
    chk("late ack ignored", 32'(seen), 32'h0);
    chk("late ack cmd_ready", 32'(cmd_ready), 32'h1);
`else
    wait_rsp(20, lat);
    chk("noack no response", 32'(lat), 32'hFFFFFFFF);
    @(negedge clk) man_ack = 1'b1;
    @(negedge clk) man_ack = 1'b0;
    wait_rsp(5, lat);
    chk("noack late ack latency", 32'(lat), 32'd1);
    chk("noack status", 32'(rsp_status), 32'd0);
    chk("noack rdata", rsp_rdata, 32'h0);
    handshake();
`endif
    chk("noack single request", 32'(req_cycles - r0), 32'd1);
    @(negedge clk) auto_ack = 1'b1;
    run(1'b0, 2'd3, 8'h10, 32'h0, lat, st, rd);
    chk("after noack latency", 32'(lat), 32'd2);
    chk("after noack status", 32'(st), 32'd0);
    chk("after noack rdata", rd, 32'hDDCCBBAA);

    // Reset while in WAIT: command is dropped, no response ever appears.
    @(negedge clk) auto_ack = 1'b0;
    send(1'b1, 2'd3, 8'h60, 32'h12345678);
    @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1 chk_reset_outputs("wait reset");
    @(negedge clk);
    reset = 1'b0; rsp_ready = 1'b1; auto_ack = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1 if (rsp_valid) seen = 1'b1;
    end
    rsp_ready = 1'b0;
    chk("aborted no response", 32'(seen), 32'h0);
    run(1'b1, 2'd2, 8'h50, 32'h0000BEEF, lat, st, rd);
    chk("post reset write status", 32'(st), 32'd0);
    run(1'b0, 2'd3, 8'h50, 32'h0, lat, st, rd);
    chk("post reset read", rd, 32'h0000BEEF);

    chk("rs_req back-to-back", 32'(consec), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
